// File: rtl/fd_decode_stage_if.sv
// Fetch-side, execute-side, register-file and interlock signals of the F/D stage.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface fd_decode_stage_if #(
    parameter int unsigned INSN_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) ();
    logic              f_valid;
    logic              f_ready;
    logic [INSN_W-1:0] f_insn;
    logic [PC_W-1:0]   f_pc;
    logic              d_valid;
    logic              d_ready;
    logic [INSN_W-1:0] d_insn;
    logic [PC_W-1:0]   d_pc;
    logic [REG_AW-1:0] read_reg_a;
    logic [REG_AW-1:0] read_reg_b;
    logic              uses_a;
    logic              uses_b;
    logic              x_load_valid;
    logic [REG_AW-1:0] x_load_rd;
    logic              flush;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output f_valid, f_insn, f_pc, d_ready, x_load_valid, x_load_rd, flush,
        input  f_ready, d_valid, d_insn, d_pc, read_reg_a, read_reg_b,
               uses_a, uses_b, stall_cnt
    );

    modport slave (
        input  f_valid, f_insn, f_pc, d_ready, x_load_valid, x_load_rd, flush,
        output f_ready, d_valid, d_insn, d_pc, read_reg_a, read_reg_b,
               uses_a, uses_b, stall_cnt
    );
endinterface

// File: rtl/fd_decode_stage.sv
// One-entry fetch/decode holding register: register-file addressing, operand
// classification, load-use interlock and branch flush.
//
// state | meaning
// EMPTY | no instruction held, fetch may load
// FULL  | instruction held; issues when no hazard (READY) or waits (STALL)
module fd_decode_stage #(
    parameter int unsigned INSN_W     = 32,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned REG_AW     = 5,
    parameter logic [31:0] RDSRC_MASK = 32'h000000D4,
    parameter logic [31:0] NOA_MASK   = 32'h0020000A,
    parameter int unsigned CNT_W      = 16
) (
    input logic           clock,
    input logic           reset,
    fd_decode_stage_if.slave bus
);
    localparam int unsigned OP_W   = 5;
    localparam int unsigned RD_LSB = INSN_W - OP_W - REG_AW;
    localparam int unsigned RS_LSB = RD_LSB - REG_AW;
    localparam int unsigned RT_LSB = RS_LSB - REG_AW;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } entryState_e;

    entryState_e       stateQ, stateD;
    logic              loadEntry;
    logic [INSN_W-1:0] insnQ;
    logic [PC_W-1:0]   pcQ;
    logic [CNT_W-1:0]  stallCntQ;

    logic              held;
    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] rdField, rsField, rtField, regB;
    logic              rdIsSrcB, noOperandA;
    logic              usesA, usesB, hazard;
    logic              dValid, fire, fReady, accept;

    // Decode looks only at the held entry so addresses are stable for a whole stall.
    assign held       = (stateQ == FULL);
    assign opcode     = insnQ[INSN_W-1 -: OP_W];
    assign rdField    = insnQ[RD_LSB +: REG_AW];
    assign rsField    = insnQ[RS_LSB +: REG_AW];
    assign rtField    = insnQ[RT_LSB +: REG_AW];
    assign rdIsSrcB   = RDSRC_MASK[opcode];
    assign noOperandA = NOA_MASK[opcode];
    assign regB       = rdIsSrcB ? rdField : rtField;
    assign usesA      = held & ~noOperandA;
    assign usesB      = held & ((opcode == '0) | rdIsSrcB);

    // r0 is hard-wired, so a load targeting it never blocks a consumer.
    assign hazard = held & bus.x_load_valid & (bus.x_load_rd != '0)
                  & ((usesA & (rsField == bus.x_load_rd))
                  |  (usesB & (regB == bus.x_load_rd)));

    assign dValid = held & ~hazard & ~bus.flush;
    assign fire   = dValid & bus.d_ready;
    // Gated by reset so fetch sees no acceptance while the stage is held in reset.
    assign fReady = reset & ~bus.flush & (~held | fire);
    assign accept = bus.f_valid & fReady;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ <= EMPTY;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        loadEntry = 1'b0;
        case (stateQ)
            EMPTY: begin
                if (accept) begin
                    stateD    = FULL;
                    loadEntry = 1'b1;
                end
            end
            FULL: begin
                if (bus.flush) begin
                    stateD = EMPTY;
                end else if (accept) begin
                    loadEntry = 1'b1;
                end else if (fire) begin
                    stateD = EMPTY;
                end
            end
            default: stateD = EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            insnQ <= '0;
            pcQ   <= '0;
        end else if (loadEntry) begin
            insnQ <= bus.f_insn;
            pcQ   <= bus.f_pc;
        end
    end

    // Flush takes precedence, so a cycle that is both flushed and hazarded is not counted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stallCntQ <= '0;
        end else if (hazard && !bus.flush && (stallCntQ != '1)) begin
            stallCntQ <= stallCntQ + CNT_W'(1);
        end
    end

    assign bus.f_ready    = fReady;
    assign bus.d_valid    = dValid;
    assign bus.d_insn     = insnQ;
    assign bus.d_pc       = pcQ;
    assign bus.read_reg_a = rsField;
    assign bus.read_reg_b = regB;
    assign bus.uses_a     = usesA;
    assign bus.uses_b     = usesB;
    assign bus.stall_cnt  = stallCntQ;
endmodule

// File: tb/tb_fd_decode_stage.sv
// Scoreboard-driven bench for the fetch/decode stage, plus a narrow-counter
// instance for stall-count saturation.
module tb_fd_decode_stage;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    fd_decode_stage_if #(.INSN_W(32), .PC_W(32), .REG_AW(5), .CNT_W(16)) dif ();
    fd_decode_stage_if #(.INSN_W(32), .PC_W(32), .REG_AW(5), .CNT_W(2))  sif ();

    fd_decode_stage #(.INSN_W(32), .PC_W(32), .REG_AW(5), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .bus(dif)
    );
    fd_decode_stage #(.INSN_W(32), .PC_W(32), .REG_AW(5), .CNT_W(2)) dutSat (
        .clock(clock), .reset(reset), .bus(sif)
    );

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
    } sbEntry_t;

    sbEntry_t sbQ[$];
    sbEntry_t monExp;
    int nTests = 0;
    int nFail  = 0;

    localparam logic [31:0] ADD_I = 32'h0088_3000;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 12'h000};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] insn, input logic [31:0] pc);
        dif.f_valid = 1'b1;
        dif.f_insn  = insn;
        dif.f_pc    = pc;
        sbQ.push_back('{insn: insn, pc: pc});
    endtask

    // Scoreboard: every issued instruction must be the oldest one sent and not dropped.
    always @(negedge clock) begin
        if (reset && dif.d_valid && dif.d_ready) begin
            nTests++;
            if (sbQ.size() == 0) begin
                nFail++;
                $display("FAIL sb_unexpected: issued insn %h pc %h, expected nothing", dif.d_insn, dif.d_pc);
            end else begin
                monExp = sbQ.pop_front();
                if (dif.d_insn !== monExp.insn || dif.d_pc !== monExp.pc) begin
                    nFail++;
                    $display("FAIL sb_issue: got insn %h pc %h, expected insn %h pc %h",
                             dif.d_insn, dif.d_pc, monExp.insn, monExp.pc);
                end
            end
        end
    end

    task automatic test_reset;
        @(negedge clock);
        nTests++; if (dif.d_valid !== 1'b0) begin nFail++; $display("FAIL rst_d_valid: got %b expected 0", dif.d_valid); end
        nTests++; if (dif.f_ready !== 1'b0) begin nFail++; $display("FAIL rst_f_ready: got %b expected 0", dif.f_ready); end
        nTests++; if (dif.stall_cnt !== 16'd0) begin nFail++; $display("FAIL rst_stall_cnt: got %0d expected 0", dif.stall_cnt); end
        nTests++; if (dif.d_insn !== 32'h0) begin nFail++; $display("FAIL rst_d_insn: got %h expected 0", dif.d_insn); end
        tick;
        reset = 1'b1;
        @(negedge clock);
        nTests++; if (dif.f_ready !== 1'b1) begin nFail++; $display("FAIL rel_f_ready: got %b expected 1", dif.f_ready); end
        nTests++; if (dif.d_valid !== 1'b0) begin nFail++; $display("FAIL rel_d_valid: got %b expected 0", dif.d_valid); end
        tick;
    endtask

    task automatic test_stream;
        logic [31:0] lw;
        lw = mk(5'd8, 5'd5, 5'd6, 5'd0);
        dif.d_ready = 1'b1;
        send(ADD_I, 32'h100);
        @(negedge clock);
        nTests++; if (dif.f_ready !== 1'b1) begin nFail++; $display("FAIL stream_f_ready0: got %b expected 1", dif.f_ready); end
        nTests++; if (dif.d_valid !== 1'b0) begin nFail++; $display("FAIL stream_latency: got %b expected 0", dif.d_valid); end
        tick;
        send(lw, 32'h104);
        @(negedge clock);
        nTests++; if (dif.d_valid !== 1'b1) begin nFail++; $display("FAIL stream_d_valid: got %b expected 1", dif.d_valid); end
        nTests++; if (dif.read_reg_a !== 5'd4) begin nFail++; $display("FAIL stream_reg_a: got %0d expected 4", dif.read_reg_a); end
        nTests++; if (dif.read_reg_b !== 5'd3) begin nFail++; $display("FAIL stream_reg_b: got %0d expected 3", dif.read_reg_b); end
        nTests++; if (dif.uses_b !== 1'b1) begin nFail++; $display("FAIL stream_uses_b: got %b expected 1", dif.uses_b); end
        nTests++; if (dif.f_ready !== 1'b1) begin nFail++; $display("FAIL stream_b2b_ready: got %b expected 1", dif.f_ready); end
        tick;
        dif.f_valid = 1'b0;
        @(negedge clock);
        nTests++; if (dif.d_valid !== 1'b1) begin nFail++; $display("FAIL stream_lw_valid: got %b expected 1", dif.d_valid); end
        nTests++; if (dif.read_reg_a !== 5'd6) begin nFail++; $display("FAIL stream_lw_reg_a: got %0d expected 6", dif.read_reg_a); end
        nTests++; if (dif.uses_b !== 1'b0) begin nFail++; $display("FAIL stream_lw_uses_b: got %b expected 0", dif.uses_b); end
        nTests++; if (dif.stall_cnt !== 16'd0) begin nFail++; $display("FAIL stream_stall: got %0d expected 0", dif.stall_cnt); end
        tick;
        @(negedge clock);
        nTests++; if (dif.d_valid !== 1'b0) begin nFail++; $display("FAIL stream_drain: got %b expected 0", dif.d_valid); end
        tick;
    endtask

    task automatic test_operand_sel;
        logic [31:0] insns [5];
        logic [4:0]  expA  [5];
        logic [4:0]  expB  [5];
        logic        expUa [5];
        logic        expUb [5];
        insns[0] = 32'h39C0_0000 | mk(5'd0, 5'd0, 5'd9, 5'd0);      // sw rd=7 rs=9
        expA[0] = 5'd9;  expB[0] = 5'd7;  expUa[0] = 1'b1; expUb[0] = 1'b1;
        insns[1] = mk(5'd5, 5'd1, 5'd2, 5'd3);                       // addi
        expA[1] = 5'd2;  expB[1] = 5'd3;  expUa[1] = 1'b1; expUb[1] = 1'b0;
        insns[2] = mk(5'd1, 5'd0, 5'd5, 5'd6);                       // j
        expA[2] = 5'd5;  expB[2] = 5'd6;  expUa[2] = 1'b0; expUb[2] = 1'b0;
        insns[3] = mk(5'd2, 5'd10, 5'd11, 5'd12);                    // bne
        expA[3] = 5'd11; expB[3] = 5'd10; expUa[3] = 1'b1; expUb[3] = 1'b1;
        insns[4] = mk(5'd21, 5'd3, 5'd4, 5'd5);                      // setx
        expA[4] = 5'd4;  expB[4] = 5'd5;  expUa[4] = 1'b0; expUb[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dif.d_ready = 1'b0;
            send(insns[i], 32'h300 + 32'(i) * 4);
            tick;
            dif.f_valid = 1'b0;
            @(negedge clock);
            nTests++; if (dif.read_reg_a !== expA[i]) begin nFail++; $display("FAIL opsel_reg_a[%0d]: got %0d expected %0d", i, dif.read_reg_a, expA[i]); end
            nTests++; if (dif.read_reg_b !== expB[i]) begin nFail++; $display("FAIL opsel_reg_b[%0d]: got %0d expected %0d", i, dif.read_reg_b, expB[i]); end
            nTests++; if (dif.uses_a !== expUa[i]) begin nFail++; $display("FAIL opsel_uses_a[%0d]: got %b expected %b", i, dif.uses_a, expUa[i]); end
            nTests++; if (dif.uses_b !== expUb[i]) begin nFail++; $display("FAIL opsel_uses_b[%0d]: got %b expected %b", i, dif.uses_b, expUb[i]); end
            nTests++; if (dif.f_ready !== 1'b0) begin nFail++; $display("FAIL opsel_f_ready[%0d]: got %b expected 0", i, dif.f_ready); end
            tick;
            dif.d_ready = 1'b1;
            @(negedge clock);
            nTests++; if (dif.d_insn !== insns[i]) begin nFail++; $display("FAIL opsel_hold[%0d]: got %h expected %h", i, dif.d_insn, insns[i]); end
            tick;
        end
        dif.d_ready = 1'b0;
    endtask

    task automatic test_load_use_stall;
        dif.d_ready      = 1'b1;
        dif.x_load_valid = 1'b1;
        dif.x_load_rd    = 5'd4;
        send(ADD_I, 32'h200);
        tick;
        dif.f_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            nTests++; if (dif.d_valid !== 1'b0) begin nFail++; $display("FAIL stall_d_valid[%0d]: got %b expected 0", i, dif.d_valid); end
            nTests++; if (dif.f_ready !== 1'b0) begin nFail++; $display("FAIL stall_f_ready[%0d]: got %b expected 0", i, dif.f_ready); end
            nTests++; if (dif.stall_cnt !== 16'(i)) begin nFail++; $display("FAIL stall_cnt[%0d]: got %0d expected %0d", i, dif.stall_cnt, i); end
            tick;
        end
        dif.x_load_valid = 1'b0;
        @(negedge clock);
        nTests++; if (dif.d_valid !== 1'b1) begin nFail++; $display("FAIL stall_issue: got %b expected 1", dif.d_valid); end
        nTests++; if (dif.stall_cnt !== 16'd3) begin nFail++; $display("FAIL stall_cnt_total: got %0d expected 3", dif.stall_cnt); end
        tick;
        // hazard through port B (rt=3), released by the load destination changing
        dif.x_load_valid = 1'b1;
        dif.x_load_rd    = 5'd3;
        send(ADD_I, 32'h204);
        tick;
        dif.f_valid = 1'b0;
        @(negedge clock);
        nTests++; if (dif.d_valid !== 1'b0) begin nFail++; $display("FAIL stall_b_d_valid: got %b expected 0", dif.d_valid); end
        tick;
        dif.x_load_rd = 5'd9;
        @(negedge clock);
        nTests++; if (dif.d_valid !== 1'b1) begin nFail++; $display("FAIL stall_b_release: got %b expected 1", dif.d_valid); end
        nTests++; if (dif.stall_cnt !== 16'd4) begin nFail++; $display("FAIL stall_b_cnt: got %0d expected 4", dif.stall_cnt); end
        tick;
        dif.x_load_valid = 1'b0;
    endtask

    task automatic test_reg_zero;
        dif.d_ready      = 1'b1;
        dif.x_load_valid = 1'b1;
        dif.x_load_rd    = 5'd0;
        send(mk(5'd0, 5'd0, 5'd0, 5'd0), 32'h300);
        tick;
        dif.f_valid = 1'b0;
        @(negedge clock);
        nTests++; if (dif.d_valid !== 1'b1) begin nFail++; $display("FAIL r0_d_valid: got %b expected 1", dif.d_valid); end
        nTests++; if (dif.stall_cnt !== 16'd4) begin nFail++; $display("FAIL r0_stall_cnt: got %0d expected 4", dif.stall_cnt); end
        tick;
        dif.x_load_valid = 1'b0;
    endtask

    task automatic test_flush;
        dif.d_ready      = 1'b0;
        dif.x_load_valid = 1'b1;
        dif.x_load_rd    = 5'd4;
        send(ADD_I, 32'h400);
        tick;
        void'(sbQ.pop_back());
        dif.d_ready = 1'b1;
        dif.flush   = 1'b1;
        dif.f_valid = 1'b1;
        dif.f_insn  = mk(5'd8, 5'd1, 5'd1, 5'd1);
        dif.f_pc    = 32'h500;
        @(negedge clock);
        nTests++; if (dif.d_valid !== 1'b0) begin nFail++; $display("FAIL flush_d_valid: got %b expected 0", dif.d_valid); end
        nTests++; if (dif.f_ready !== 1'b0) begin nFail++; $display("FAIL flush_f_ready: got %b expected 0", dif.f_ready); end
        tick;
        dif.flush        = 1'b0;
        dif.f_valid      = 1'b0;
        dif.x_load_valid = 1'b0;
        @(negedge clock);
        nTests++; if (dif.d_valid !== 1'b0) begin nFail++; $display("FAIL flush_dropped: got %b expected 0", dif.d_valid); end
        nTests++; if (dif.stall_cnt !== 16'd4) begin nFail++; $display("FAIL flush_stall_cnt: got %0d expected 4", dif.stall_cnt); end
        nTests++; if (dif.f_ready !== 1'b1) begin nFail++; $display("FAIL flush_after_ready: got %b expected 1", dif.f_ready); end
        tick;
    endtask

    task automatic test_async_reset;
        dif.d_ready = 1'b0;
        send(mk(5'd9, 5'd1, 5'd2, 5'd3), 32'h600);
        tick;
        dif.f_valid = 1'b0;
        @(negedge clock);
        nTests++; if (dif.d_valid !== 1'b1) begin nFail++; $display("FAIL arst_full: got %b expected 1", dif.d_valid); end
        #2;
        reset = 1'b0;
        sbQ.delete();
        #1;
        nTests++; if (dif.d_valid !== 1'b0) begin nFail++; $display("FAIL arst_d_valid: got %b expected 0", dif.d_valid); end
        nTests++; if (dif.f_ready !== 1'b0) begin nFail++; $display("FAIL arst_f_ready: got %b expected 0", dif.f_ready); end
        nTests++; if (dif.stall_cnt !== 16'd0) begin nFail++; $display("FAIL arst_stall_cnt: got %0d expected 0", dif.stall_cnt); end
        nTests++; if (dif.d_insn !== 32'h0) begin nFail++; $display("FAIL arst_d_insn: got %h expected 0", dif.d_insn); end
        tick;
        reset = 1'b1;
        dif.d_ready = 1'b1;
        send(mk(5'd10, 5'd4, 5'd5, 5'd6), 32'h700);
        @(negedge clock);
        nTests++; if (dif.f_ready !== 1'b1) begin nFail++; $display("FAIL arst_rel_ready: got %b expected 1", dif.f_ready); end
        nTests++; if (dif.d_valid !== 1'b0) begin nFail++; $display("FAIL arst_rel_valid: got %b expected 0", dif.d_valid); end
        tick;
        dif.f_valid = 1'b0;
        @(negedge clock);
        nTests++; if (dif.d_valid !== 1'b1) begin nFail++; $display("FAIL arst_next_valid: got %b expected 1", dif.d_valid); end
        tick;
        dif.d_ready = 1'b0;
    endtask

    task automatic test_saturate;
        logic [1:0] expSat;
        sif.d_ready      = 1'b0;
        sif.x_load_valid = 1'b1;
        sif.x_load_rd    = 5'd4;
        sif.f_valid      = 1'b1;
        sif.f_insn       = ADD_I;
        sif.f_pc         = 32'h800;
        tick;
        sif.f_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expSat = (i > 3) ? 2'd3 : 2'(i);
            @(negedge clock);
            nTests++; if (sif.stall_cnt !== expSat) begin nFail++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, sif.stall_cnt, expSat); end
            tick;
        end
        @(negedge clock);
        nTests++; if (sif.stall_cnt !== 2'd3) begin nFail++; $display("FAIL sat_final: got %0d expected 3", sif.stall_cnt); end
        nTests++; if (sif.d_valid !== 1'b0) begin nFail++; $display("FAIL sat_d_valid: got %b expected 0", sif.d_valid); end
        tick;
        sif.x_load_valid = 1'b0;
        sif.d_ready      = 1'b1;
        tick;
        sif.d_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        dif.f_valid = 1'b0; dif.f_insn = '0; dif.f_pc = '0; dif.d_ready = 1'b0;
        dif.x_load_valid = 1'b0; dif.x_load_rd = '0; dif.flush = 1'b0;
        sif.f_valid = 1'b0; sif.f_insn = '0; sif.f_pc = '0; sif.d_ready = 1'b0;
        sif.x_load_valid = 1'b0; sif.x_load_rd = '0; sif.flush = 1'b0;
        test_reset;
        test_stream;
        test_operand_sel;
        test_load_use_stall;
        test_reg_zero;
        test_flush;
        test_async_reset;
        test_saturate;
        nTests++;
        if (sbQ.size() != 0) begin
            nFail++;
            $display("FAIL sb_leftover: %0d entries never issued, expected 0", sbQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
